// File: rtl/bcd_counter_multi.sv
// Multi-digit 8421-BCD up/down counter with prescaler, synchronous clear and validated parallel load.
// Optional build macro BCD_CNT_SATURATE_EN: saturate at all-9 / all-0 instead of wrapping.
module bcd_counter_multi #(
    parameter int DIGITS = 4,
    parameter int DIV    = 2,
    parameter int DIV_W  = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tick,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] pre_q, pre_d;
    logic [W-1:0]     count_q, count_d, stepped;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             step, load_ok, roll;
    logic [DIGITS:0]  carry;
    logic [3:0]       dig;

    assign step = en && (pre_q == PRE_LAST);

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    // Ripple carry/borrow chain across digits; every digit stays in 0-9.
    always_comb begin
        stepped  = count_q;
        carry    = '0;
        carry[0] = 1'b1;
        dig      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry[i]) begin
                if (up_dn) begin
                    stepped[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                    carry[i+1]        = (dig == 4'd9);
                end else begin
                    stepped[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                    carry[i+1]        = (dig == 4'd0);
                end
            end
        end
        roll = carry[DIGITS];
    end

    always_comb begin
        pre_d      = pre_q;
        count_d    = count_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            pre_d   = '0;
            count_d = '0;
        end else begin
            if (en) pre_d = step ? '0 : pre_q + DIV_W'(1);
            // A load wins over a step due in the same cycle; the step is dropped.
            if (load) begin
                if (load_ok) count_d = load_val;
                else         load_err_d = 1'b1;
            end else if (step) begin
                tick_d = 1'b1;
                wrap_d = roll;
`ifdef BCD_CNT_SATURATE_EN
                count_d = roll ? count_q : stepped;
`else
                count_d = stepped;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi (DIGITS=2, DIV=3): directed stimulus, expected strobes queued with their cycle.
module tb_bcd_counter_multi;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, clr, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick, wrap, load_err;

    logic [31:0] cyc = '0;
    int          checks = 0;
    int          failures = 0;

    // Entry layout: {cycle[31:0], load_err, wrap, count[7:0]}
    logic [41:0] exp_q[$];

`ifdef BCD_CNT_SATURATE_EN
    localparam logic [7:0] UP_WRAP_VAL = 8'h99;
    localparam logic [7:0] DN_WRAP_VAL = 8'h00;
`else
    localparam logic [7:0] UP_WRAP_VAL = 8'h00;
    localparam logic [7:0] DN_WRAP_VAL = 8'h99;
`endif

    bcd_counter_multi #(.DIGITS(2), .DIV(3), .DIV_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap),
        .load_err (load_err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_en(input int n);
        en = 1'b1;
        repeat (n) edge_step();
        en = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        edge_step();
        load     = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] c, input logic le, input logic w, input logic [7:0] v);
        exp_q.push_back({c, le, w, v});
    endtask

    task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
        @(negedge clk);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard: pops one entry per presented strobe
    always @(negedge clk) begin
        logic [41:0] e;
        if (tick || load_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: tick=%b load_err=%b wrap=%b count=%h cyc=%0d",
                         tick, load_err, wrap, count, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({cyc, tick, load_err, wrap, count} !== {e[41:10], ~e[9], e[9:0]}) begin
                    failures++;
                    $display("FAIL strobe: got cyc=%0d tick=%b load_err=%b wrap=%b count=%h, expected cyc=%0d tick=%b load_err=%b wrap=%b count=%h",
                             cyc, tick, load_err, wrap, count, e[41:10], ~e[9], e[9], e[8], e[7:0]);
                end
            end
        end else if (wrap) begin
            checks++;
            failures++;
            $display("FAIL wrap_without_tick: wrap=1 tick=0 cyc=%0d", cyc);
        end
    end

    initial begin
        logic [31:0] c0;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        repeat (2) edge_step();
        rst = 1'b0;
        check_now("reset_count", {24'd0, count}, 32'h00);
        check_now("reset_tick", {31'd0, tick}, 32'd0);
        check_now("reset_wrap", {31'd0, wrap}, 32'd0);
        check_now("reset_load_err", {31'd0, load_err}, 32'd0);

        // Count up 00 -> 10, one step every third enabled cycle
        c0 = cyc;
        for (int k = 1; k <= 10; k++) begin
            push_exp(c0 + 32'(3 * k), 1'b0, 1'b0, (k < 10) ? 8'(k) : 8'h10);
        end
        run_en(30);
        check_now("up_to_10", {24'd0, count}, 32'h10);

        // Load on a step-due cycle: load wins, no tick
        run_en(2);
        en = 1'b1;
        do_load(8'h45);
        en = 1'b0;
        check_now("load_over_step", {24'd0, count}, 32'h45);
        clr = 1'b1;
        edge_step();
        clr = 1'b0;
        check_now("clr_count", {24'd0, count}, 32'h00);

        // Up wrap 98 -> 99 -> 00
        do_load(8'h98);
        check_now("load_98", {24'd0, count}, 32'h98);
        c0 = cyc;
        push_exp(c0 + 32'd3, 1'b0, 1'b0, 8'h99);
        push_exp(c0 + 32'd6, 1'b0, 1'b1, UP_WRAP_VAL);
        run_en(6);

        // Down wrap 01 -> 00 -> 99
        up_dn = 1'b0;
        do_load(8'h01);
        c0 = cyc;
        push_exp(c0 + 32'd3, 1'b0, 1'b0, 8'h00);
        push_exp(c0 + 32'd6, 1'b0, 1'b1, DN_WRAP_VAL);
        run_en(6);

        // Rejected loads: low digit and high digit out of range
        c0 = cyc;
        push_exp(c0 + 32'd1, 1'b1, 1'b0, DN_WRAP_VAL);
        do_load(8'h3A);
        check_now("bad_load_lo_hold", {24'd0, count}, {24'd0, DN_WRAP_VAL});
        c0 = cyc;
        push_exp(c0 + 32'd1, 1'b1, 1'b0, DN_WRAP_VAL);
        do_load(8'hA5);
        check_now("bad_load_hi_hold", {24'd0, count}, {24'd0, DN_WRAP_VAL});

        // Enable hold mid-prescale
        up_dn = 1'b1;
        do_load(8'h20);
        run_en(1);
        repeat (5) edge_step();
        c0 = cyc;
        push_exp(c0 + 32'd2, 1'b0, 1'b0, 8'h21);
        en = 1'b1;
        edge_step();
        check_now("hold_no_early_tick", {31'd0, tick}, 32'd0);
        edge_step();
        en = 1'b0;
        check_now("hold_tick_after_2", {31'd0, tick}, 32'd1);
        check_now("hold_count", {24'd0, count}, 32'h21);

        // clr and load together: clr wins, prescaler cleared
        run_en(1);
        en = 1'b1; clr = 1'b1; load = 1'b1; load_val = 8'h55;
        edge_step();
        en = 1'b0; clr = 1'b0; load = 1'b0;
        check_now("clr_load_count", {24'd0, count}, 32'h00);
        check_now("clr_load_err", {31'd0, load_err}, 32'd0);
        c0 = cyc;
        push_exp(c0 + 32'd3, 1'b0, 1'b0, 8'h01);
        run_en(3);
        check_now("after_clr_count", {24'd0, count}, 32'h01);

        // rst mid-count with every other input active
        run_en(1);
        rst = 1'b1; clr = 1'b1; en = 1'b1; up_dn = 1'b0; load = 1'b1; load_val = 8'h77;
        edge_step();
        rst = 1'b0; clr = 1'b0; en = 1'b0; load = 1'b0; up_dn = 1'b1;
        check_now("rst_mid_count", {24'd0, count}, 32'h00);
        check_now("rst_mid_tick", {31'd0, tick}, 32'd0);
        check_now("rst_mid_wrap", {31'd0, wrap}, 32'd0);
        check_now("rst_mid_load_err", {31'd0, load_err}, 32'd0);
        c0 = cyc;
        push_exp(c0 + 32'd3, 1'b0, 1'b0, 8'h01);
        run_en(3);
        check_now("after_rst_count", {24'd0, count}, 32'h01);

        repeat (3) edge_step();
        check_now("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
